// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: two row line buffers plus a 3x3 shift array,
// emitting each fully-populated window (no padding) one cycle after its last pixel is accepted.
module window_gen_3x3 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] win0,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
  output logic                     win_valid,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          win_hit;

  logic signed [DATA_W-1:0] lb0 [IMG_W];
  logic signed [DATA_W-1:0] lb1 [IMG_W];

  // sh[r][c]: r = window row (0 oldest), c = window column (0 leftmost)
  logic signed [DATA_W-1:0] sh [3][3];
  logic signed [DATA_W-1:0] new_top, new_mid, new_bot;
  logic signed [DATA_W-1:0] win_q [9];

  assign in_ready   = (state == FILL) || (state == RUN);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  assign accept   = in_valid && in_ready;
  assign col_last = (col == COL_LAST);
  assign win_hit  = accept && (row >= RW'(2)) && (col >= CW'(2));

  assign new_top = lb1[col];
  assign new_mid = lb0[col];
  assign new_bot = in_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (accept && (row == RW'(1)) && col_last) state_nxt = RUN;
      RUN:     if (accept && (row == ROW_LAST) && col_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == DONE) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Storage only; stale contents are never exposed because windows need col>=2 and row>=2.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_data;
      sh[0][0] <= sh[0][1];
      sh[0][1] <= sh[0][2];
      sh[0][2] <= new_top;
      sh[1][0] <= sh[1][1];
      sh[1][1] <= sh[1][2];
      sh[1][2] <= new_mid;
      sh[2][0] <= sh[2][1];
      sh[2][1] <= sh[2][2];
      sh[2][2] <= new_bot;
    end
  end

  // Window captured from the post-shift view: columns 1,2 of the array plus the incoming column.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_q     <= '{default: '0};
    end else begin
      win_valid <= win_hit;
      if (win_hit) begin
        win_q[0] <= sh[0][1];
        win_q[1] <= sh[0][2];
        win_q[2] <= new_top;
        win_q[3] <= sh[1][1];
        win_q[4] <= sh[1][2];
        win_q[5] <= new_mid;
        win_q[6] <= sh[2][1];
        win_q[7] <= sh[2][2];
        win_q[8] <= new_bot;
      end
    end
  end

  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 (5x4 frames): pixel-grid reference model checked every cycle,
// plus literal expectations for selected windows and strobe counts.
module tb_window_gen_3x3;

  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic in_ready, win_valid, frame_done, busy;
  logic signed [DW-1:0] w [9];

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .win0(w[0]), .win1(w[1]), .win2(w[2]), .win3(w[3]), .win4(w[4]),
    .win5(w[5]), .win6(w[6]), .win7(w[7]), .win8(w[8]),
    .win_valid(win_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  // Reference model: phase 0 idle, 1 accepting, 2 done; windows read from a pixel grid.
  int m_phase = 0;
  int mr = 0;
  int mc = 0;
  logic signed [DW-1:0] grid [H][W];
  logic signed [DW-1:0] exp_win [9];
  bit exp_valid = 1'b0;

  initial for (int k = 0; k < 9; k++) exp_win[k] = '0;

  always @(posedge clk) begin
    exp_valid = 1'b0;
    if (rst) begin
      m_phase = 0;
      mr = 0;
      mc = 0;
      for (int k = 0; k < 9; k++) exp_win[k] = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          mr = 0;
          mc = 0;
        end
        1: if (in_valid) begin
          grid[mr][mc] = in_data;
          if (mr >= 2 && mc >= 2) begin
            exp_valid = 1'b1;
            for (int k = 0; k < 9; k++) exp_win[k] = grid[mr-2+k/3][mc-2+k%3];
          end
          if (mr == H-1 && mc == W-1) m_phase = 2;
          if (mc == W-1) begin
            mc = 0;
            mr++;
          end else begin
            mc++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  logic [9*DW-1:0] wins [$];
  int done_cnt = 0;
  int done_last = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit bad;
        bit exp_done, exp_ready, exp_busy;
        logic [9*DW-1:0] pk;
        bad = 1'b0;
        exp_done  = (m_phase == 2);
        exp_ready = (m_phase == 1);
        exp_busy  = (m_phase != 0);
        vectors++;
        if (win_valid !== exp_valid) begin
          $display("FAIL win_valid t=%0t act=%0b exp=%0b", $time, win_valid, exp_valid);
          bad = 1'b1;
        end
        if (frame_done !== exp_done) begin
          $display("FAIL frame_done t=%0t act=%0b exp=%0b", $time, frame_done, exp_done);
          bad = 1'b1;
        end
        if (in_ready !== exp_ready) begin
          $display("FAIL in_ready t=%0t act=%0b exp=%0b", $time, in_ready, exp_ready);
          bad = 1'b1;
        end
        if (busy !== exp_busy) begin
          $display("FAIL busy t=%0t act=%0b exp=%0b", $time, busy, exp_busy);
          bad = 1'b1;
        end
        for (int k = 0; k < 9; k++) begin
          if (w[k] !== exp_win[k]) begin
            $display("FAIL win%0d t=%0t act=%0d exp=%0d", k, $time, w[k], exp_win[k]);
            bad = 1'b1;
          end
        end
        if (bad) errors++;
        if (win_valid) begin
          for (int k = 0; k < 9; k++) pk[k*DW +: DW] = w[k];
          wins.push_back(pk);
        end
        if (frame_done) done_cnt++;
        if (frame_done && win_valid) done_last++;
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic int wk(input logic [9*DW-1:0] p, input int k);
    logic signed [DW-1:0] v;
    v = p[k*DW +: DW];
    return int'(v);
  endfunction

  task automatic clear_stats();
    wins.delete();
    done_cnt = 0;
    done_last = 0;
  endtask

  task automatic run_frame(input int base, input bit neg, input bit gap, input int npx);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < npx; i++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_data = neg ? -16'sd1 : 16'(base + i);
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 16'h7777;
      end
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_win(input string name, input int idx, input int base);
    int f [9];
    f = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    if (idx >= wins.size()) begin
      lit({name, "_present"}, 0, 1);
    end else begin
      for (int k = 0; k < 9; k++)
        lit($sformatf("%s_w%0d", name, k), wk(wins[idx], k), base + f[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    lit("reset_busy", int'(busy), 0);
    lit("reset_win_valid", int'(win_valid), 0);
    lit("reset_in_ready", int'(in_ready), 0);
    rst = 1'b0;

    // 1: back-to-back frame
    clear_stats();
    run_frame(0, 1'b0, 1'b0, W*H);
    idle(3);
    lit("s1_count", wins.size(), 6);
    lit("s1_done", done_cnt, 1);
    lit("s1_done_last", done_last, 1);
    check_win("s1_first", 0, 0);
    check_win("s1_last", 5, 7);

    // 2: input stalls every other cycle
    clear_stats();
    run_frame(0, 1'b0, 1'b1, W*H);
    idle(3);
    lit("s2_count", wins.size(), 6);
    check_win("s2_first", 0, 0);
    check_win("s2_last", 5, 7);

    // 3: valid data without start is ignored
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 16'sd55;
    end
    @(negedge clk);
    lit("s3_ready", int'(in_ready), 0);
    lit("s3_busy", int'(busy), 0);
    lit("s3_count_idle", wins.size(), 0);
    run_frame(0, 1'b0, 1'b0, W*H);
    idle(3);
    lit("s3_count", wins.size(), 6);
    check_win("s3_first", 0, 0);

    // 4: reset mid-frame, then a clean frame
    clear_stats();
    run_frame(0, 1'b0, 1'b0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("s4_busy", int'(busy), 0);
    lit("s4_win4", int'(w[4]), 0);
    lit("s4_win8", int'(w[8]), 0);
    lit("s4_count_abort", wins.size(), 0);
    idle(2);
    run_frame(0, 1'b0, 1'b0, W*H);
    idle(3);
    lit("s4_count", wins.size(), 6);
    check_win("s4_first", 0, 0);
    check_win("s4_last", 5, 7);

    // 5: two frames back-to-back, second offset by 100
    clear_stats();
    run_frame(0, 1'b0, 1'b0, W*H);
    run_frame(100, 1'b0, 1'b0, W*H);
    idle(3);
    lit("s5_count", wins.size(), 12);
    lit("s5_done", done_cnt, 2);
    check_win("s5_f2_first", 6, 100);
    check_win("s5_f2_last", 11, 107);

    // 6: all pixels -1
    clear_stats();
    run_frame(0, 1'b1, 1'b0, W*H);
    idle(3);
    lit("s6_count", wins.size(), 6);
    lit("s6_done", done_cnt, 1);
    for (int i = 0; i < wins.size(); i++)
      lit($sformatf("s6_win%0d_all_ones", i), int'(wins[i] == {(9*DW){1'b1}}), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
